// File: rtl/edp_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edp_mdu_pkg
// Description : Shared types for the serial multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package edp_mdu_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } tMDUstate;

   typedef enum logic {
      mduMUL = 1'b0,
      mduDIV = 1'b1
   } tMDUop;

endpackage
`default_nettype wire

// File: rtl/edp_mdu_neg.sv
`default_nettype none
// ============================================================================
// Module      : edp_mdu_neg
// Description : Conditional two's complement negate of an N-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
module edp_mdu_neg
   import edp_mdu_pkg::*;
#(
   parameter int N = 36
) (
   input  logic         negate,
   input  logic [N-1:0] value,
   output logic [N-1:0] result
);

   assign result = negate ? -value : value;

endmodule
`default_nettype wire

// File: rtl/edp_mdu.sv
`default_nettype none
// ============================================================================
// Module      : edp_mdu
// Description : Serial signed multiply (shift-and-add) / divide (non-restoring)
//               unit, one radix-2 step per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module edp_mdu
   import edp_mdu_pkg::*;
#(
   parameter int W  = 36,
   parameter int CW = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic         op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic         dchk,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   localparam logic [W-1:0] C_MIN = {1'b1, {(W-1){1'b0}}};

   tMDUstate        r_state, w_next;
   tMDUop           r_op;
   logic [W:0]      r_partial;
   logic [W-1:0]    r_mq, r_opnd, r_hi, r_lo;
   logic [CW-1:0]   r_cnt;
   logic            r_signA, r_signB, r_dchk;

   logic            w_divChk;
   logic [W:0]      w_mulSum, w_mulAdd, w_mulP, w_divSh, w_divP;
   logic [W-1:0]    w_mulMQ, w_divMQ, w_rem, w_negA, w_negB;
   logic [2*W-1:0]  w_prod;
   logic            w_isFix;

   // Before ITER the latches still hold raw two's complement operands.
   assign w_divChk = (r_op == mduDIV) &&
                     ((r_opnd == '0) || ((r_mq == C_MIN) && (r_opnd == '1)));

   // Shift-and-add: {partial, MQ} shifts right, adding the multiplicand on MQ[0].
   assign w_mulSum = {1'b0, r_partial[W-1:0]} + {1'b0, r_opnd};
   assign w_mulAdd = r_mq[0] ? w_mulSum : r_partial;
   assign w_mulP   = {1'b0, w_mulAdd[W:1]};
   assign w_mulMQ  = {w_mulAdd[0], r_mq[W-1:1]};

   // Non-restoring: add or subtract the divisor by the sign of the partial remainder.
   assign w_divSh  = {r_partial[W-1:0], r_mq[W-1]};
   assign w_divP   = r_partial[W] ? (w_divSh + {1'b0, r_opnd}) : (w_divSh - {1'b0, r_opnd});
   assign w_divMQ  = {r_mq[W-2:0], ~w_divP[W]};
   assign w_rem    = r_partial[W] ? (r_partial[W-1:0] + r_opnd) : r_partial[W-1:0];

   // The two W-bit negators form magnitudes in LOAD and fix signs in FIX.
   assign w_isFix = (r_state == FIX);

   edp_mdu_neg #(.N(W)) u_negA (
      .negate (w_isFix ? (r_signA ^ r_signB) : r_mq[W-1]),
      .value  (r_mq),
      .result (w_negA)
   );

   edp_mdu_neg #(.N(W)) u_negB (
      .negate (w_isFix ? r_signA : r_opnd[W-1]),
      .value  (w_isFix ? w_rem : r_opnd),
      .result (w_negB)
   );

   edp_mdu_neg #(.N(2*W)) u_negP (
      .negate (r_signA ^ r_signB),
      .value  ({r_partial[W-1:0], r_mq}),
      .result (w_prod)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (start && !abort) w_next = LOAD;
         LOAD: begin
            if (abort)         w_next = IDLE;
            else if (w_divChk) w_next = DONE;
            else               w_next = ITER;
         end
         ITER: begin
            if (abort)                  w_next = IDLE;
            else if (r_cnt == CW'(1))   w_next = FIX;
         end
         FIX:     w_next = abort ? IDLE : DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op      <= mduMUL;
         r_partial <= '0;
         r_mq      <= '0;
         r_opnd    <= '0;
         r_cnt     <= '0;
         r_signA   <= 1'b0;
         r_signB   <= 1'b0;
         r_dchk    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  r_mq   <= a;
                  r_opnd <= b;
                  r_op   <= tMDUop'(op);
                  r_dchk <= 1'b0;
               end
            end
            LOAD: begin
               r_signA   <= r_mq[W-1];
               r_signB   <= r_opnd[W-1];
               r_mq      <= w_negA;
               r_opnd    <= w_negB;
               r_partial <= '0;
               r_cnt     <= CW'(W);
               r_dchk    <= w_divChk;
            end
            ITER: begin
               if (r_op == mduMUL) begin
                  r_partial <= w_mulP;
                  r_mq      <= w_mulMQ;
               end else begin
                  r_partial <= w_divP;
                  r_mq      <= w_divMQ;
               end
               r_cnt <= r_cnt - 1'b1;
            end
            FIX: begin
               if (!abort) begin
                  if (r_op == mduMUL) begin
                     r_hi <= w_prod[2*W-1:W];
                     r_lo <= w_prod[W-1:0];
                  end else begin
                     r_hi <= w_negA;
                     r_lo <= w_negB;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign dchk = done && r_dchk;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/edp_mdu.md
EDP_MDU -- requirements
Module: edp_mdu

Interface
REQ-001 Parameter W, default 36, operand width; even, 8..72.
REQ-002 Parameter CW, default $clog2(W+1), iteration counter width.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 abort  input  1  cancel current operation.
REQ-007 op  input  1  0 = signed multiply (MUL), 1 = signed divide (DIV).
REQ-008 a  input  W  multiplicand / dividend, two's complement.
REQ-009 b  input  W  multiplier / divisor, two's complement.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 dchk  output  1  divide check; valid while done=1.
REQ-013 hi  output  W  MUL: product bits [2W-1:W]; DIV: quotient.
REQ-014 lo  output  W  MUL: product bits [W-1:0]; DIV: remainder.

Function
REQ-015 FSM states: IDLE, LOAD, ITER, FIX, DONE.
REQ-016 Accept: IDLE with start=1 and abort=0; latch a, b and op; next state LOAD.
REQ-017 start outside IDLE is ignored; no queueing.
REQ-018 LOAD: latch operand signs; form magnitudes; clear the partial register; set counter to W.
REQ-019 LOAD, DIV: b=0, or a=-2^(W-1) with b=-1 -> DONE with dchk=1; hi/lo unchanged.
REQ-020 LOAD otherwise -> ITER.
REQ-021 ITER: one radix-2 step per cycle, counter decrements; at counter=1 -> FIX (exactly W ITER cycles).
REQ-022 MUL step: shift-and-add on magnitudes (AR/MQ style); 2W-bit unsigned magnitude product.
REQ-023 DIV step: non-restoring on magnitudes; FIX applies the final remainder restore.
REQ-024 FIX, MUL: negate the 2W-bit product when sign(a) != sign(b); load hi/lo.
REQ-025 FIX, DIV: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (truncating); load hi/lo.
REQ-026 FIX -> DONE; DONE -> IDLE unconditionally.
REQ-027 done=1 only in DONE: W+3 cycles after accept edge (normal), 2 cycles (divide check).
REQ-028 dchk=0 for MUL and normal DIV; dchk=0 whenever done=0.
REQ-029 hi/lo change only on FIX exit; otherwise hold last result.
REQ-030 abort=1 in LOAD, ITER or FIX -> IDLE next edge; no done; hi/lo unchanged.
REQ-031 abort=1 in DONE: done still pulses; IDLE next.
REQ-032 abort=1 with start=1 in IDLE: start ignored.
REQ-033 Multiply never overflows; -2^(W-1) x -2^(W-1) yields exact 2W-bit result.

Reset
REQ-034 reset=1 -> state IDLE, counter 0, busy=0, done=0, dchk=0, hi=0, lo=0, internal registers 0.
REQ-035 reset overrides abort and start; reset mid-operation discards the operation with no done pulse.

Structure
REQ-036 Package edp_mdu_pkg holds the state enum (tMDUstate) and the op enum (mduMUL, mduDIV).
REQ-037 Sub-module edp_mdu_neg: parametrised-width two's complement conditional negate; used for input magnitudes and output sign fixup.
REQ-038 Datapath registers: partial (W+1 bits), MQ (W bits), operand latch (W bits), counter (CW bits).

Verification (W=36, octal values)
REQ-039 MUL a=3, b=-5 -> done at cycle 39; hi=777777777777, lo=777777777761, dchk=0.
REQ-040 MUL a=b=400000000000 -> hi=200000000000, lo=0.
REQ-041 DIV a=144, b=7 -> hi=16, lo=2; DIV a=-144, b=7 -> hi=777777777762, lo=777777777776.
REQ-042 DIV b=0; then a=400000000000, b=-1 -> each: done at cycle 2, dchk=1, hi/lo unchanged.
REQ-043 abort at ITER cycle 10 -> busy=0 next cycle, no done; an immediate new MUL 2x3 gives lo=6.
REQ-044 reset during ITER -> all outputs 0 next cycle; start in busy/DONE states ignored (no second done).
